div_seq_64bit: RTL and testbench

- Multi-cycle restoring integer divider controller for the EX stage ALU.
- Sequences a single 64-bit ripple subtractor (the ALU full-subtractor datapath, Bin tied 0) over WIDTH iterations to produce quotient and remainder.
- Provides a start/busy/done handshake so the pipeline stall logic can hold EX while a DIV/DIVU/REM/REMU is in flight.

---
 rtl/div_seq_64bit.sv | 131 +++++++++++++
 tb/tb_div_seq_64bit.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/div_seq_64bit.sv
// Multi-cycle restoring divider: one subtractor iterated WIDTH times, with
// start/busy/done handshake and signed correction in a final FIX step.
module div_seq_64bit #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ITER,
    S_FIX,
    S_DONE
  } state_t;

  state_t           state, state_next;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] div_r;
  logic             neg_q;
  logic             neg_r;

  logic [WIDTH-1:0] abs_dividend;
  logic [WIDTH-1:0] abs_divisor;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] diff;
  logic             carry_out;
  logic             bout;
  logic             take;

  assign abs_dividend = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
  assign abs_divisor  = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

  // The single subtractor. A bit shifted out of rem means the true partial
  // remainder is >= 2^WIDTH, so it always exceeds the divisor.
  assign shifted         = {rem_r[WIDTH-2:0], q_r[WIDTH-1]};
  assign carry_out       = rem_r[WIDTH-1];
  assign {bout, diff}    = {1'b0, shifted} - {1'b0, div_r};
  assign take            = carry_out | ~bout;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // NOTE: every output of this block gets a default first so no path through
  // the case statement leaves a signal unassigned and infers a latch.
  always_comb begin
    state_next = state;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_next = S_CHECK;
      end
      S_CHECK: state_next = (div_r == '0) ? S_DONE : S_ITER;
      S_ITER:  if (count == '0) state_next = S_FIX;
      S_FIX:   state_next = S_DONE;
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count       <= '0;
      rem_r       <= '0;
      q_r         <= '0;
      div_r       <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      div_by_zero <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            q_r         <= abs_dividend;
            div_r       <= abs_divisor;
            neg_q       <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r       <= is_signed & dividend[WIDTH-1];
            div_by_zero <= 1'b0;
          end
        end
        S_CHECK: begin
          if (div_r == '0) begin
            // Re-apply the sign to recover the original dividend.
            quotient    <= '1;
            remainder   <= neg_r ? -q_r : q_r;
            div_by_zero <= 1'b1;
          end else begin
            rem_r <= '0;
            count <= CW'(WIDTH - 1);
          end
        end
        S_ITER: begin
          rem_r <= take ? diff : shifted;
          q_r   <= {q_r[WIDTH-2:0], take};
          count <= count - 1'b1;
        end
        S_FIX: begin
          quotient  <= neg_q ? -q_r : q_r;
          remainder <= neg_r ? -rem_r : rem_r;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_64bit.sv
// Self-checking bench for div_seq_64bit: directed handshake/latency cases plus
// randomized operations against an arithmetic reference model.
module tb_div_seq_64bit;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         is_signed;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  div_seq_64bit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .quotient    (quotient),
    .remainder   (remainder)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: truncating division, remainder follows dividend sign;
  // x/0 gives all ones and the untouched dividend.
  function automatic void ref_div(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r);
    longint sa, sb;
    if (b == '0) begin
      q = '1;
      r = a;
    end else if (!s) begin
      q = a / b;
      r = a % b;
    end else if (a == 64'h8000_0000_0000_0000 && b == '1) begin
      q = a;
      r = '0;
    end else begin
      sa = a;
      sb = b;
      q  = sa / sb;
      r  = sa % sb;
    end
  endfunction

  // Drives start during cycle 0, returns in cycle 1 with start low.
  task automatic launch(input logic s, input logic [W-1:0] a, input logic [W-1:0] b, output int base);
    is_signed = s;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    base      = cyc;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_done(input int base, output int at);
    while (!done && (cyc - base) < 200) tick();
    at = cyc - base;
  endtask

  task automatic run_op(input string tag, input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] eq, er;
    int base, at, lat;
    ref_div(s, a, b, eq, er);
    lat = (b == '0) ? 2 : W + 3;
    launch(s, a, b, base);
    check({tag, ".busy1"}, W'(busy), W'(1));
    check({tag, ".dbz_clr"}, W'(div_by_zero), W'(0));
    wait_done(base, at);
    check({tag, ".done_cyc"}, W'(at), W'(lat));
    check({tag, ".q"}, quotient, eq);
    check({tag, ".r"}, remainder, er);
    check({tag, ".dbz"}, W'(div_by_zero), W'(b == '0));
    tick();
    check({tag, ".idle"}, W'({busy, done}), W'(0));
    check({tag, ".q_hold"}, quotient, eq);
  endtask

  initial begin
    int base, at;
    logic [W-1:0] a, b;
    logic s;

    rst = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst.busy", W'(busy), W'(0));
    check("rst.done", W'(done), W'(0));
    check("rst.dbz", W'(div_by_zero), W'(0));
    check("rst.q", quotient, '0);
    check("rst.r", remainder, '0);

    run_op("u100_7", 1'b0, 64'd100, 64'd7);
    run_op("umax_1", 1'b0, '1, 64'd1);
    run_op("umax_max", 1'b0, '1, '1);
    run_op("s-7_2", 1'b1, -64'sd7, 64'd2);
    run_op("s7_-2", 1'b1, 64'd7, -64'sd2);
    run_op("smin_-1", 1'b1, 64'h8000_0000_0000_0000, '1);
    run_op("div0", 1'b0, 64'h1234, '0);
    run_op("after0", 1'b0, 64'd50, 64'd5);
    run_op("sdiv0", 1'b1, -64'sd9, '0);

    // Starts while busy (cycle 5 and the DONE cycle) must be ignored.
    launch(1'b0, 64'd100, 64'd7, base);
    while ((cyc - base) < 5) tick();
    start = 1'b1; is_signed = 1'b1; dividend = 64'd55; divisor = 64'd5;
    tick();
    start = 1'b0;
    wait_done(base, at);
    check("ign.done_cyc", W'(at), W'(67));
    start = 1'b1; dividend = 64'd99; divisor = 64'd9;
    tick();
    start = 1'b0;
    check("ign.busy68", W'(busy), W'(0));
    check("ign.q", quotient, 64'd14);
    check("ign.r", remainder, 64'd2);

    // Reset mid-ITER discards everything.
    launch(1'b0, 64'd1000, 64'd3, base);
    while ((cyc - base) < 30) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst.busy", W'(busy), W'(0));
    check("mid_rst.done", W'(done), W'(0));
    check("mid_rst.q", quotient, '0);
    check("mid_rst.r", remainder, '0);
    run_op("u9_3", 1'b0, 64'd9, 64'd3);

    for (int i = 0; i < 24; i++) begin
      s = 1'($urandom);
      a = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0:       b = {$urandom, $urandom};
        1:       b = W'($urandom_range(0, 20));
        2:       b = -W'($urandom_range(1, 20));
        default: b = W'($urandom);
      endcase
      if ($urandom_range(0, 3) == 0) a = W'($urandom_range(0, 1000));
      run_op($sformatf("rnd%0d", i), s, a, b);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
